// File: rtl/ad4003_frame_packer.sv
// ---------------------------------------------------------------------------
// ad4003_frame_packer
//
// Purpose:
//   Sits after the AD4003 deserializer in the adc_read_clk domain. Detects the
//   falling edge of the deserializer shift enable (end of an 18-bit window),
//   snapshots every channel word, and emits one 64-bit AXI4-Stream packet per
//   conversion frame: a header beat followed by ADC_CHANNELS/2 channel-pair
//   beats with each sample sign-extended to 32 bits. Frames that arrive while
//   the previous packet is still in flight are dropped and counted.
//
// Ports:
//   adc_read_clk   clock (deserializer read clock)
//   rst            asynchronous active-high reset
//   acq_en         acquisition enable; frame edges are ignored while low
//   status_clr     single-cycle pulse clearing overrun_cnt / overrun_flag
//   adc_shift_en   deserializer shift enable (already synchronised)
//   adc_data_arr   channel words, channel k at [ADC_DATA_WIDTH*k +: ADC_DATA_WIDTH]
//   m_axis_*       64-bit AXI4-Stream master (tdata/tvalid/tready/tlast)
//   frame_cnt      frames detected while enabled (accepted + dropped), wraps
//   overrun_cnt    dropped frames, saturating
//   overrun_flag   sticky drop indicator
//   busy           packet in progress
// ---------------------------------------------------------------------------
module ad4003_frame_packer #(
  parameter int          ADC_CHANNELS   = 8,
  parameter int          ADC_DATA_WIDTH = 18,
  parameter logic [15:0] HDR_MAGIC      = 16'hAD40,
  parameter int          TCQ            = 1
) (
  input  logic                                   adc_read_clk,
  input  logic                                   rst,
  input  logic                                   acq_en,
  input  logic                                   status_clr,
  input  logic                                   adc_shift_en,
  input  logic [ADC_DATA_WIDTH*ADC_CHANNELS-1:0] adc_data_arr,
  output logic [63:0]                            m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   m_axis_tlast,
  output logic [31:0]                            frame_cnt,
  output logic [15:0]                            overrun_cnt,
  output logic                                   overrun_flag,
  output logic                                   busy
);

  localparam int PAIRS  = ADC_CHANNELS / 2;
  localparam int BEAT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int SNAP_W = ADC_DATA_WIDTH * ADC_CHANNELS;
  localparam int EXT_W  = 32 - ADC_DATA_WIDTH;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAIRS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;

  // Elaboration-time guard on the supported parameter range. TCQ only models
  // clock-to-q in behavioural simulation and has no effect on this netlist.
  generate
    if (ADC_CHANNELS < 2 || ADC_CHANNELS > 48 || (ADC_CHANNELS % 2) != 0 ||
        ADC_DATA_WIDTH < 2 || ADC_DATA_WIDTH > 31 || TCQ < 0) begin : g_bad_params
      $error("ad4003_frame_packer: unsupported parameter set");
    end
  endgenerate

  logic [1:0]        state_reg, state_next;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic [63:0]       tdata_reg, tdata_next;
  logic              tvalid_reg, tvalid_next;
  logic              tlast_reg, tlast_next;
  logic [SNAP_W-1:0] snapshot_reg, snapshot_next;
  logic              shift_en_d_reg;
  logic [31:0]       frame_cnt_reg;
  logic [15:0]       overrun_cnt_reg;
  logic              overrun_flag_reg;

  logic frame_edge;
  logic handshake;
  logic last_hs;
  logic accept;
  logic drop;

  assign frame_edge = shift_en_d_reg & ~adc_shift_en;
  assign handshake  = tvalid_reg & m_axis_tready;
  assign last_hs    = handshake & tlast_reg;
  // A new frame may start either from idle or exactly on the final handshake
  // of the previous packet, so back-to-back frames lose no cycle.
  assign accept     = frame_edge & acq_en & ((state_reg == ST_IDLE) | last_hs);
  assign drop       = frame_edge & acq_en & ~accept;

  // Pre-formatted data beats built from the snapshot: odd channel in the
  // high word, even channel in the low word, each sign-extended to 32 bits.
  logic [63:0] beat_word [PAIRS];

  genvar gi;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : g_beat
      logic [ADC_DATA_WIDTH-1:0] ch_even;
      logic [ADC_DATA_WIDTH-1:0] ch_odd;
      assign ch_even = snapshot_reg[(2*gi)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      assign ch_odd  = snapshot_reg[(2*gi+1)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
      assign beat_word[gi] = {{EXT_W{ch_odd[ADC_DATA_WIDTH-1]}}, ch_odd,
                              {EXT_W{ch_even[ADC_DATA_WIDTH-1]}}, ch_even};
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    tdata_next    = tdata_reg;
    tvalid_next   = tvalid_reg;
    tlast_next    = tlast_reg;
    snapshot_next = snapshot_reg;

    if (accept) begin
      // The header carries the frame count before this frame's increment.
      state_next    = ST_HEADER;
      beat_next     = '0;
      tdata_next    = {HDR_MAGIC, 16'(ADC_CHANNELS), frame_cnt_reg};
      tvalid_next   = 1'b1;
      tlast_next    = 1'b0;
      snapshot_next = adc_data_arr;
    end else if (handshake) begin
      case (state_reg)
        ST_HEADER: begin
          state_next = ST_DATA;
          beat_next  = '0;
          tdata_next = beat_word[0];
          tlast_next = (PAIRS == 1);
        end
        ST_DATA: begin
          if (tlast_reg) begin
            state_next  = ST_IDLE;
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
          end else begin
            beat_next  = beat_reg + 1'b1;
            tdata_next = beat_word[beat_next];
            tlast_next = (beat_next == LAST_BEAT);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_reg     <= '0;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      snapshot_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      tdata_reg    <= tdata_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      snapshot_reg <= snapshot_next;
    end
  end

  // Frame edge detection and status counters. Dropped frames still advance
  // frame_cnt so downstream sees a gap in the header sequence numbers.
  always_ff @(posedge adc_read_clk or posedge rst) begin
    if (rst) begin
      shift_en_d_reg   <= 1'b0;
      frame_cnt_reg    <= '0;
      overrun_cnt_reg  <= '0;
      overrun_flag_reg <= 1'b0;
    end else begin
      shift_en_d_reg <= adc_shift_en;

      if (frame_edge && acq_en) begin
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end

      // A drop coinciding with a clear is not lost: it becomes the first
      // event of the new counting period.
      if (status_clr) begin
        overrun_cnt_reg  <= drop ? 16'd1 : 16'd0;
        overrun_flag_reg <= drop;
      end else if (drop) begin
        if (overrun_cnt_reg != 16'hFFFF) begin
          overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
        end
        overrun_flag_reg <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tlast  = tlast_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign overrun_cnt   = overrun_cnt_reg;
  assign overrun_flag  = overrun_flag_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ad4003_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_ad4003_frame_packer
//
// Self-checking bench for ad4003_frame_packer (8 channels x 18 bits).
// Expected beats are pushed to a scoreboard queue when a frame is issued and
// popped by a monitor whenever the DUT completes a stream handshake.
// ---------------------------------------------------------------------------
module tb_ad4003_frame_packer;

  localparam int NCH = 8;
  localparam int DW  = 18;

  logic              adc_read_clk = 1'b0;
  logic              rst          = 1'b1;
  logic              acq_en       = 1'b0;
  logic              status_clr   = 1'b0;
  logic              adc_shift_en = 1'b0;
  logic [NCH*DW-1:0] adc_data_arr = '0;
  logic [63:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic [31:0]       frame_cnt;
  logic [15:0]       overrun_cnt;
  logic              overrun_flag;
  logic              busy;

  ad4003_frame_packer #(
    .ADC_CHANNELS  (NCH),
    .ADC_DATA_WIDTH(DW),
    .HDR_MAGIC     (16'hAD40),
    .TCQ           (1)
  ) dut (
    .adc_read_clk (adc_read_clk),
    .rst          (rst),
    .acq_en       (acq_en),
    .status_clr   (status_clr),
    .adc_shift_en (adc_shift_en),
    .adc_data_arr (adc_data_arr),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .frame_cnt    (frame_cnt),
    .overrun_cnt  (overrun_cnt),
    .overrun_flag (overrun_flag),
    .busy         (busy)
  );

  always #5 adc_read_clk = ~adc_read_clk;

  int errors = 0;
  int checks = 0;
  int beats_seen = 0;

  // Scoreboard entries are {tlast, tdata}.
  logic [64:0] sb[$];

  logic [31:0] m_frame_cnt = '0;
  logic [15:0] m_overrun   = '0;
  logic        m_flag      = 1'b0;

  function automatic logic [31:0] sext(input logic [DW-1:0] s);
    return {{(32-DW){s[DW-1]}}, s};
  endfunction

  function automatic logic [NCH*DW-1:0] rand_data();
    logic [NCH*DW-1:0] d;
    for (int k = 0; k < NCH; k++) begin
      d[k*DW +: DW] = DW'($urandom);
    end
    return d;
  endfunction

  task automatic model_accept(input logic [NCH*DW-1:0] d);
    sb.push_back({1'b0, 16'hAD40, 16'd8, m_frame_cnt});
    for (int b = 0; b < NCH/2; b++) begin
      sb.push_back({(b == NCH/2 - 1), sext(d[(2*b+1)*DW +: DW]), sext(d[(2*b)*DW +: DW])});
    end
    m_frame_cnt = m_frame_cnt + 32'd1;
  endtask

  task automatic model_drop(input bit clr);
    m_frame_cnt = m_frame_cnt + 32'd1;
    if (clr) m_overrun = 16'd1;
    else if (m_overrun != 16'hFFFF) m_overrun = m_overrun + 16'd1;
    m_flag = 1'b1;
  endtask

  // Monitor: every handshake must match the next expected beat.
  always @(negedge adc_read_clk) begin
    logic [64:0] exp_beat;
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      checks++;
      beats_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got tdata=%h tlast=%b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        exp_beat = sb.pop_front();
        if ({m_axis_tlast, m_axis_tdata} !== exp_beat) begin
          errors++;
          $display("FAIL beat_data: got tlast=%b tdata=%h, required tlast=%b tdata=%h",
                   m_axis_tlast, m_axis_tdata, exp_beat[64], exp_beat[63:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge adc_read_clk); #1;
    rst = 1'b1;
    sb.delete();
    m_frame_cnt = '0;
    m_overrun   = '0;
    m_flag      = 1'b0;
    repeat (2) @(posedge adc_read_clk);
    #1 rst = 1'b0;
  endtask

  // Pulses the shift enable for one cycle; the frame edge is the next cycle.
  // Returns one cycle after the frame-edge cycle (tvalid visible if accepted).
  task automatic issue_frame(input logic [NCH*DW-1:0] d, input bit expect_accept, input bit clr_in_fe);
    @(posedge adc_read_clk); #1;
    adc_data_arr = d;
    adc_shift_en = 1'b1;
    @(posedge adc_read_clk); #1;
    adc_shift_en = 1'b0;
    status_clr   = clr_in_fe;
    if (acq_en) begin
      if (expect_accept) model_accept(d);
      else model_drop(clr_in_fe);
    end
    @(posedge adc_read_clk); #1;
    status_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_axis_tready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge adc_read_clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
    end
    repeat (2) @(posedge adc_read_clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got tvalid=%b busy=%b, required 0 0", name, m_axis_tvalid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge adc_read_clk);
    #1 rst = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream: got tvalid=%b tlast=%b tdata=%h busy=%b, required 0 0 0 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy);
    end
    checks++;
    if (frame_cnt !== 32'd0 || overrun_cnt !== 16'd0 || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got frame_cnt=%0d overrun_cnt=%0d flag=%b, required 0 0 0",
               frame_cnt, overrun_cnt, overrun_flag);
    end
  endtask

  task automatic test_async_reset();
    acq_en = 1'b1;
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b tvalid=%b, required 1 1", busy, m_axis_tvalid);
    end
    @(negedge adc_read_clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 || frame_cnt !== 32'd0) begin
      errors++;
      $display("FAIL areset_mid: got tvalid=%b tlast=%b busy=%b frame_cnt=%0d, required 0 0 0 0",
               m_axis_tvalid, m_axis_tlast, busy, frame_cnt);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [NCH*DW-1:0] d;
    int start_beats;
    d = '0;
    d[0*DW +: DW] = 18'h1FFFF;
    d[1*DW +: DW] = 18'h20000;
    d[2*DW +: DW] = 18'h00001;
    d[3*DW +: DW] = 18'h3FFFF;
    d[4*DW +: DW] = 18'h12345;
    d[5*DW +: DW] = 18'h2ABCD;
    d[6*DW +: DW] = 18'h00000;
    d[7*DW +: DW] = 18'h1ABCD;
    acq_en = 1'b1;
    m_axis_tready = 1'b1;
    start_beats = beats_seen;
    issue_frame(d, 1'b1, 1'b0);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'hAD40_0008_0000_0000) begin
      errors++;
      $display("FAIL basic_header: got tvalid=%b tdata=%h, required 1 ad40000800000000", m_axis_tvalid, m_axis_tdata);
    end
    @(posedge adc_read_clk); #1;
    checks++;
    if (m_axis_tdata !== 64'hFFFE0000_0001FFFF) begin
      errors++;
      $display("FAIL basic_beat1: got %h, required fffe00000001ffff", m_axis_tdata);
    end
    drain("basic");
    checks++;
    if (beats_seen - start_beats != 5 || frame_cnt !== 32'd1) begin
      errors++;
      $display("FAIL basic_count: got beats=%0d frame_cnt=%0d, required 5 1", beats_seen - start_beats, frame_cnt);
    end
  endtask

  task automatic test_stall();
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    m_axis_tready = 1'b1;
    repeat (2) @(posedge adc_read_clk);
    #1 m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adc_data_arr = rand_data();
      @(negedge adc_read_clk);
      checks++;
      if (sb.size() == 0 || m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tdata} !== sb[0]) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got tvalid=%b tlast=%b tdata=%h, required held pending beat",
                 i, m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
    end
    @(posedge adc_read_clk); #1;
    drain("stall");
    checks++;
    if (frame_cnt !== m_frame_cnt) begin
      errors++;
      $display("FAIL stall_frame_cnt: got %0d, required %0d", frame_cnt, m_frame_cnt);
    end
  endtask

  task automatic test_overrun();
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    issue_frame(rand_data(), 1'b0, 1'b0);
    checks++;
    if (overrun_cnt !== m_overrun || overrun_flag !== 1'b1 || frame_cnt !== m_frame_cnt) begin
      errors++;
      $display("FAIL overrun_drop: got cnt=%0d flag=%b frame_cnt=%0d, required %0d 1 %0d",
               overrun_cnt, overrun_flag, frame_cnt, m_overrun, m_frame_cnt);
    end
    drain("overrun_a");
    m_axis_tready = 1'b1;
    issue_frame(rand_data(), 1'b1, 1'b0);
    drain("overrun_gap");
    @(posedge adc_read_clk); #1 status_clr = 1'b1;
    @(posedge adc_read_clk); #1 status_clr = 1'b0;
    m_overrun = '0;
    m_flag = 1'b0;
    checks++;
    if (overrun_cnt !== 16'd0 || overrun_flag !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got cnt=%0d flag=%b, required 0 0", overrun_cnt, overrun_flag);
    end
    // Clear and drop in the same cycle: the drop survives.
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    issue_frame(rand_data(), 1'b0, 1'b1);
    checks++;
    if (overrun_cnt !== m_overrun || overrun_flag !== m_flag) begin
      errors++;
      $display("FAIL overrun_clr_drop: got cnt=%0d flag=%b, required %0d %b",
               overrun_cnt, overrun_flag, m_overrun, m_flag);
    end
    drain("overrun_b");
  endtask

  task automatic test_back_to_back();
    logic [NCH*DW-1:0] db;
    logic [63:0] hdr_exp;
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    m_axis_tready = 1'b1;
    repeat (4) @(posedge adc_read_clk);
    #1 m_axis_tready = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
      errors++;
      $display("FAIL b2b_last_pending: got tvalid=%b tlast=%b, required 1 1", m_axis_tvalid, m_axis_tlast);
    end
    db = rand_data();
    @(posedge adc_read_clk); #1;
    adc_data_arr = db;
    adc_shift_en = 1'b1;
    @(posedge adc_read_clk); #1;
    adc_shift_en  = 1'b0;
    m_axis_tready = 1'b1;
    hdr_exp = {16'hAD40, 16'd8, m_frame_cnt};
    model_accept(db);
    @(posedge adc_read_clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tdata !== hdr_exp) begin
      errors++;
      $display("FAIL b2b_header: got tvalid=%b tlast=%b tdata=%h, required 1 0 %h",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, hdr_exp);
    end
    drain("b2b");
  endtask

  task automatic test_acq_disabled();
    do_reset();
    acq_en = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_frame(rand_data(), 1'b1, 1'b0);
      checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL acq_off_pulse%0d: got tvalid=%b busy=%b, required 0 0", i, m_axis_tvalid, busy);
      end
    end
    checks++;
    if (frame_cnt !== 32'd0 || overrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL acq_off_counts: got frame_cnt=%0d overrun_cnt=%0d, required 0 0", frame_cnt, overrun_cnt);
    end
    // acq_en falling mid-packet: packet completes, later edges ignored.
    acq_en = 1'b1;
    m_axis_tready = 1'b0;
    issue_frame(rand_data(), 1'b1, 1'b0);
    acq_en = 1'b0;
    issue_frame(rand_data(), 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || frame_cnt !== 32'd1 || overrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL acq_fall: got busy=%b frame_cnt=%0d overrun_cnt=%0d, required 1 1 0",
               busy, frame_cnt, overrun_cnt);
    end
    drain("acq_fall");
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_acq_disabled();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
